// File: rtl/dct2_pkg.sv
// Shared definitions for the forward DCT-II pipeline: size codes, lane geometry,
// and packed-vector lane access helpers.
package dct2_pkg;

   localparam int unsigned LANE_W    = 16;
   localparam int unsigned MAX_LANES = 32;

   typedef logic [MAX_LANES*LANE_W-1:0] vec_t;

   // Encoding is shared with the DCT stage N select.
   typedef enum logic [1:0] {
      SZ4  = 2'b00,
      SZ8  = 2'b01,
      SZ16 = 2'b10,
      SZ32 = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FILL  = 2'b01,
      DRAIN = 2'b10
   } buf_state_t;

   function automatic int unsigned n_of(input size_t size);
      case (size)
         SZ4:     return 4;
         SZ8:     return 8;
         SZ16:    return 16;
         default: return 32;
      endcase
   endfunction

   function automatic logic [LANE_W-1:0] lane_get(input vec_t v, input int unsigned k);
      return v[k*LANE_W +: LANE_W];
   endfunction

   function automatic vec_t lane_set(input vec_t v, input int unsigned k,
                                     input logic [LANE_W-1:0] x);
      vec_t t;
      t = v;
      t[k*LANE_W +: LANE_W] = x;
      return t;
   endfunction

endpackage

// File: rtl/dct2_transpose_buffer.sv
// Single-buffered NxN transpose between the row and column passes of the 2-D DCT-II:
// collects N rows, then emits N columns; lanes at or above N are never written or shown.
module dct2_transpose_buffer
   import dct2_pkg::*;
#(
   parameter int unsigned W     = dct2_pkg::LANE_W,
   parameter int unsigned LANES = dct2_pkg::MAX_LANES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         size_i,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES*W-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES*W-1:0] out_data,
   output logic [1:0]         out_size,
   output logic               out_last
);

   localparam int unsigned CW = $clog2(LANES);

   buf_state_t    state, state_n;
   size_t         size_q, size_n, wr_size;
   logic [CW-1:0] r, r_n, c, c_n, c_last, wr_row;
   logic          wr_en;
   logic [LANES-1:0] wr_mask, rd_mask;
   logic [W-1:0]  mem [LANES][LANES];

   // The first row arrives in IDLE, before the size is latched, so its mask uses size_i.
   assign wr_size = (state == IDLE) ? size_t'(size_i) : size_q;
   assign c_last  = CW'(n_of(size_q) - 1);

   always_comb begin
      wr_mask = '0;
      rd_mask = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         wr_mask[k] = (k < n_of(wr_size));
         rd_mask[k] = (k < n_of(size_q));
      end
   end

   always_comb begin
      state_n   = state;
      size_n    = size_q;
      r_n       = r;
      c_n       = c;
      wr_en     = 1'b0;
      wr_row    = r;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  wr_en   = 1'b1;
                  wr_row  = '0;
                  size_n  = size_t'(size_i);
                  r_n     = CW'(1);
                  state_n = FILL;
               end
            end
            FILL: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  wr_en = 1'b1;
                  if (r == c_last) begin
                     r_n     = '0;
                     c_n     = '0;
                     state_n = DRAIN;
                  end else begin
                     r_n = r + 1'b1;
                  end
               end
            end
            DRAIN: begin
               out_valid = 1'b1;
               if (out_ready) begin
                  if (c == c_last) begin
                     c_n     = '0;
                     state_n = IDLE;
                  end else begin
                     c_n = c + 1'b1;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         size_q <= SZ4;
         r      <= '0;
         c      <= '0;
      end else begin
         state  <= state_n;
         size_q <= size_n;
         r      <= r_n;
         c      <= c_n;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned k = 0; k < LANES; k++) begin
            if (wr_mask[k]) mem[wr_row][k] <= in_data[k*W +: W];
         end
      end
   end

   always_comb begin
      out_data = '0;
      if (out_valid) begin
         for (int unsigned k = 0; k < LANES; k++) begin
            if (rd_mask[k]) out_data[k*W +: W] = mem[k][c];
         end
      end
   end

   assign out_last = out_valid && (c == c_last);
   assign out_size = rst ? 2'b00 : size_q;

endmodule

// File: tb/tb_dct2_transpose_buffer.sv
// Directed bench for dct2_transpose_buffer: transposes blocks of every size under
// backpressure, input gaps, mid-block reset and signed extremes.
module tb_dct2_transpose_buffer;
   import dct2_pkg::*;

   localparam int unsigned W = LANE_W;
   localparam int unsigned L = MAX_LANES;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] size_i;
   logic       in_valid;
   logic       in_ready;
   vec_t       in_data;
   logic       out_valid;
   logic       out_ready;
   vec_t       out_data;
   logic [1:0] out_size;
   logic       out_last;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   dct2_transpose_buffer #(.W(W), .LANES(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .size_i    (size_i),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_size  (out_size),
      .out_last  (out_last)
   );

   // Entry (r,k) of each test block, by block kind.
   function automatic logic [15:0] val(input int kind, input int r, input int k);
      case (kind)
         0:       return 16'(10*r + k);
         1:       return 16'(r*32 + k - 512);
         2:       return 16'(32'h1000 + r*16 + k);
         3:       return 16'(32'h4000 + r*256 + k);
         4:       return 16'(32'h5A00 + r*8 + k);
         5:       return 16'(32'h0300 + r*16 + k);
         default: return (((r + k) % 2) != 0) ? 16'h8000 : 16'h7FFF;
      endcase
   endfunction

   function automatic vec_t row_vec(input int kind, input int unsigned n, input int unsigned r);
      vec_t v;
      v = '0;
      for (int unsigned k = 0; k < L; k++)
         v = lane_set(v, k, (k < n) ? val(kind, int'(r), int'(k)) : 16'h7FFF);
      return v;
   endfunction

   function automatic vec_t col_vec(input int kind, input int unsigned n, input int unsigned c);
      vec_t v;
      v = '0;
      for (int unsigned k = 0; k < L; k++)
         v = lane_set(v, k, (k < n) ? val(kind, int'(k), int'(c)) : 16'h0000);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_s(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_v(input string tag, input vec_t obs, input vec_t exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_block(input int kind, input int unsigned n, input logic [1:0] code);
      for (int unsigned r = 0; r < n; r++) begin
         size_i   = code;
         in_valid = 1'b1;
         in_data  = row_vec(kind, n, r);
         chk_b("fill_ready", in_ready, 1'b1);
         chk_b("fill_no_valid", out_valid, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      in_data  = '0;
      chk_b("first_col_latency", out_valid, 1'b1);
   endtask

   task automatic drain_block(input int kind, input int unsigned n, input logic [1:0] code);
      for (int unsigned c = 0; c < n; c++) begin
         out_ready = 1'b1;
         chk_b("drain_valid", out_valid, 1'b1);
         chk_v("drain_data", out_data, col_vec(kind, n, c));
         chk_b("drain_last", out_last, (c == n - 1));
         chk_s("drain_size", out_size, code);
         chk_b("drain_no_ready", in_ready, 1'b0);
         tick();
      end
      out_ready = 1'b0;
      chk_b("post_drain_valid", out_valid, 1'b0);
      chk_b("post_drain_ready", in_ready, 1'b1);
   endtask

   initial begin
      int unsigned ec;
      int unsigned stalls;
      int unsigned rows;
      logic        tog;

      rst       = 1'b1;
      size_i    = 2'b00;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      tick();
      tick();
      chk_b("rst_in_ready", in_ready, 1'b0);
      chk_b("rst_out_valid", out_valid, 1'b0);
      chk_b("rst_out_last", out_last, 1'b0);
      chk_s("rst_out_size", out_size, 2'b00);
      chk_v("rst_out_data", out_data, '0);
      rst = 1'b0;
      #1;
      chk_b("idle_in_ready", in_ready, 1'b1);

      // N=4 with garbage in the upper lanes
      send_block(0, 4, 2'b00);
      drain_block(0, 4, 2'b00);

      // N=32 back to back: every fill and drain cycle must be productive
      send_block(1, 32, 2'b11);
      drain_block(1, 32, 2'b11);

      // N=8 under toggling backpressure with a 5-cycle stall on column 3
      send_block(2, 8, 2'b01);
      ec     = 0;
      stalls = 0;
      tog    = 1'b1;
      for (int cyc = 0; cyc < 40 && ec < 8; cyc++) begin
         if (ec == 3 && stalls < 5) begin
            out_ready = 1'b0;
            stalls++;
         end else begin
            out_ready = tog;
            tog       = ~tog;
         end
         chk_b("bp_valid", out_valid, 1'b1);
         chk_v("bp_data", out_data, col_vec(2, 8, ec));
         chk_b("bp_last", out_last, (ec == 7));
         chk_b("bp_no_ready", in_ready, 1'b0);
         tick();
         if (out_ready) ec++;
      end
      out_ready = 1'b0;
      chk_i("bp_columns", int'(ec), 8);
      chk_b("bp_end_valid", out_valid, 1'b0);

      // N=16 with gaps; size_i changes after the first row and must be ignored
      rows = 0;
      for (int cyc = 0; cyc < 40 && rows < 16; cyc++) begin
         in_valid = ((cyc % 2) == 0);
         size_i   = (rows == 0) ? 2'b10 : 2'b11;
         in_data  = in_valid ? row_vec(3, 16, rows) : '1;
         chk_b("gap_no_valid", out_valid, 1'b0);
         if (in_valid) chk_b("gap_ready", in_ready, 1'b1);
         tick();
         if (in_valid) rows++;
      end
      in_valid = 1'b0;
      in_data  = '0;
      chk_i("gap_rows", int'(rows), 16);
      chk_b("gap_drain_start", out_valid, 1'b1);
      drain_block(3, 16, 2'b10);

      // Reset after 5 rows of an N=8 block
      for (int unsigned r = 0; r < 5; r++) begin
         size_i   = 2'b01;
         in_valid = 1'b1;
         in_data  = row_vec(4, 8, r);
         tick();
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk_b("mid_rst_in_ready", in_ready, 1'b0);
      chk_b("mid_rst_out_valid", out_valid, 1'b0);
      chk_b("mid_rst_out_last", out_last, 1'b0);
      chk_s("mid_rst_out_size", out_size, 2'b00);
      chk_v("mid_rst_out_data", out_data, '0);
      tick();
      rst = 1'b0;
      #1;
      chk_b("after_rst_ready", in_ready, 1'b1);
      chk_b("after_rst_valid", out_valid, 1'b0);
      send_block(5, 4, 2'b00);
      drain_block(5, 4, 2'b00);

      // Signed extremes in a checkerboard
      send_block(6, 4, 2'b00);
      drain_block(6, 4, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
